win_gen_3x3: RTL and testbench
==============================

Name: win_gen_3x3

Overview:
- Streaming 3x3 window generator on the producer side of the convolution datapath.
- Accepts a raster-order unsigned 8-bit pixel stream, one pixel per accepted cycle, and buffers two previous rows.
- Emits a full 3x3 window on the win00..win22 bus with a valid strobe, feeding the MAC's in_valid and win inputs directly.
- Produces "valid" (no padding) windows only, plus per-window coordinates and an end-of-frame pulse.

Parameters:
- IMG_W, 28: pixels per row; must be 3 or more.
- IMG_H, 28: rows per frame; must be 3 or more.
- CW, 5: width of the row/col counters; must satisfy 2^CW >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_pixel is valid this cycle; there is no backpressure and every valid pixel is accepted
- in_pixel  in  8  unsigned pixel, raster order, row-major
- out_valid  out  1  window bus holds a new valid window this cycle (single-cycle pulse per window)
- win00..win22  out  8 each  window; winRC = row R, col C; win00 = pixel (r-2,c-2), win22 = pixel (r,c)
- out_row  out  CW  centre row of the emitted window (r-1)
- out_col  out  CW  centre col of the emitted window (c-1)
- frame_done  out  1  one-cycle pulse, coincident with out_valid of the last window of the frame

Behaviour:
- Reset:
  - All outputs are 0; row/col counters are 0; state is S_IDLE.
  - Line-buffer contents are don't-care, because S_FILL overwrites them before any window is emitted.
- Idle cycles: with in_valid=0 nothing changes (counters, buffers, shift regs hold) and out_valid=0. Gaps of any length are legal anywhere in a frame.
- Datapath on each accepted pixel (r,c):
  - Line buffer lb0 (depth IMG_W) delays the pixel by one row and yields (r-1,c).
  - lb1 (depth IMG_W) is chained after lb0 and yields (r-2,c).
  - The 3x3 window register shifts left one column. The new right column becomes {lb1 out, lb0 out, in_pixel} for rows 0/1/2.
- Window emission:
  - out_valid is registered, high exactly 1 cycle after accepting (r,c) when r>=2 and c>=2.
  - The window regs are the output regs: latency 1 cycle, no combinational in-to-out path.
  - Columns carried over from the previous row's tail are masked because c<2.
- Counters:
  - col increments on each accept and wraps at IMG_W-1 to 0; on that wrap row increments.
  - On accept of (IMG_H-1, IMG_W-1) both counters go to 0, and frame_done plus the final out_valid assert the next cycle.
- State machine (advances only on accepted pixels):
  - S_IDLE -> S_FILL on the first accepted pixel.
  - S_FILL (rows 0-1) -> S_RUN when row becomes 2.
  - S_RUN -> S_IDLE on the last pixel of the frame.
- Back-to-back frames: a pixel accepted in the cycle frame_done is high is pixel (0,0) of the next frame. No bubble is required.
- Window count per frame: (IMG_W-2)*(IMG_H-2).
- Reset mid-frame: immediate abort; the next accepted pixel is (0,0) of a new frame; no stale window is ever emitted.

Optional Feature:
- Macro: WIN_STRIDE2_EN.
- Defined: out_valid additionally requires (r-2) even and (c-2) even, giving ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) windows per frame.
  - frame_done still pulses exactly 1 cycle after the last pixel is accepted.
  - out_valid may be 0 in that frame_done cycle if the last window position is skipped.
- Undefined: stride 1 as described above.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W=8;
  - the state enum {S_IDLE, S_FILL, S_RUN}, 2 bits;
  - default image dimension constants shared with the MAC/weight blocks.
- One natural sub-module, line_buffer: a parameterised DEPTH x PIX_W delay line with shift-enable. It is instantiated twice (lb0, lb1).

Test Plan (IMG_W=IMG_H=5, pixel value = 5r+c):
- Single frame, in_valid held high -> first out_valid 1 cycle after pixel 12: win00..02=0,1,2, win10..12=5,6,7, win20..22=10,11,12, out_row=1, out_col=1. Exactly 9 windows; the last is win22=24 with frame_done=1.
- Same frame with random in_valid gaps (1-7 idle cycles) -> the same 9 windows, identical values and order; out_valid never asserted during idle cycles.
- Row boundary -> no out_valid after pixels 15 and 16 (c=0,1); the next window follows pixel 17 with win20=15, win21=16, win22=17.
- rst_n pulsed low after pixel 13 -> all outputs 0 immediately. The next 25-pixel frame yields exactly 9 correct windows, and no window mixes pre-reset data.
- Two back-to-back frames, second frame offset +100 -> 18 windows. Frame-2 first window is win00=100, win22=112; frame_done pulses exactly twice.
- WIN_STRIDE2_EN defined -> exactly 4 windows, centres (1,1), (1,3), (3,1), (3,3); win22 = 12, 14, 22, 24; frame_done coincides with the win22=24 window.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath: pixel width,
// default image geometry and the window-generator state encoding.
package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int CW_DEF    = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// DEPTH-entry shift-register delay line with shift enable; dout is the
// sample that was written DEPTH enabled cycles ago.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = PIX_W
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the fill rows overwrite every entry before a window can use it.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/win_gen_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream (valid windows only).
// Define WIN_STRIDE2_EN to emit only windows at even row/col offsets (stride 2).
module win_gen_3x3
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] win00,
    output logic [PIX_W-1:0] win01,
    output logic [PIX_W-1:0] win02,
    output logic [PIX_W-1:0] win10,
    output logic [PIX_W-1:0] win11,
    output logic [PIX_W-1:0] win12,
    output logic [PIX_W-1:0] win20,
    output logic [PIX_W-1:0] win21,
    output logic [PIX_W-1:0] win22,
    output logic [CW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             frame_done
);

    state_e                         state_q, state_d;
    logic [CW-1:0]                  row_q, row_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [CW-1:0]                  out_row_q, out_col_q;
    logic                           out_valid_q, frame_done_q;
    logic [2:0][2:0][PIX_W-1:0]     win_q;
    logic [PIX_W-1:0]               lb0_out, lb1_out;
    logic                           col_last, row_last;
    logic                           win_hit, frame_end;

    line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb0 (
        .clk  (clk),
        .en   (in_valid),
        .din  (in_pixel),
        .dout (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (in_valid),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == CW'(IMG_H - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        win_hit   = 1'b0;
        frame_end = 1'b0;
        if (in_valid) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + CW'(1);
            end
            frame_end = col_last && row_last;
            // S_RUN is exactly r>=2, so only the column test remains.
            win_hit = (state_q == S_RUN) && (col_q >= CW'(2));
`ifdef WIN_STRIDE2_EN
            win_hit = win_hit && !row_q[0] && !col_q[0];
`endif
            case (state_q)
                S_IDLE:  state_d = S_FILL;
                S_FILL:  if (col_last && row_q == CW'(1)) state_d = S_RUN;
                S_RUN:   if (frame_end) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_valid_q  <= win_hit;
            frame_done_q <= frame_end;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_out;
                win_q[1][2] <= lb0_out;
                win_q[2][2] <= in_pixel;
            end
            if (win_hit) begin
                out_row_q <= row_q - CW'(1);
                out_col_q <= col_q - CW'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign win00      = win_q[0][0];
    assign win01      = win_q[0][1];
    assign win02      = win_q[0][2];
    assign win10      = win_q[1][0];
    assign win11      = win_q[1][1];
    assign win12      = win_q[1][2];
    assign win20      = win_q[2][0];
    assign win21      = win_q[2][1];
    assign win22      = win_q[2][2];

endmodule

// File: tb/tb_win_gen_3x3.sv
// Directed bench for win_gen_3x3 on a 5x5 frame with pixel value 5r+c (+offset).
module tb_win_gen_3x3;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 3;

    typedef struct packed {
        logic [71:0]   win;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic          fd;
    } rec_t;

    typedef struct {
        int   cr;   // expected centre row
        int   cc;   // expected centre col
        logic fd;   // expected frame_done with this window
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_pixel = 8'd0;
    logic          out_valid, frame_done;
    logic [7:0]    win00, win01, win02, win10, win11, win12, win20, win21, win22;
    logic [CW-1:0] out_row, out_col;

    win_gen_3x3 #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .win00      (win00), .win01 (win01), .win02 (win02),
        .win10      (win10), .win11 (win11), .win12 (win12),
        .win20      (win20), .win21 (win21), .win22 (win22),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic       acc_prev = 1'b0;
    logic [7:0] pix_prev = 8'd0;
    int         idle_viol = 0;
    int         fd_count = 0;
    rec_t       capq[$];
    logic [7:0] lastq[$];

    always @(posedge clk) begin
        acc_prev <= in_valid;
        if (in_valid) pix_prev <= in_pixel;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (!acc_prev) idle_viol++;
                capq.push_back({win00, win01, win02, win10, win11, win12,
                                win20, win21, win22, out_row, out_col, frame_done});
                lastq.push_back(pix_prev);
            end
            if (frame_done) fd_count++;
        end
    end

    // ---------------- expected-window model ----------------
    function automatic rec_t mk(input int cr, input int cc, input logic fd, input int off);
        rec_t r;
        r.win = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int c = 0; c < 3; c++) begin
                r.win[71 - 8*(3*rr + c) -: 8] = 8'(5*(cr - 1 + rr) + (cc - 1 + c) + off);
            end
        end
        r.row = CW'(cr);
        r.col = CW'(cc);
        r.fd  = fd;
        return r;
    endfunction

    vec_t tbl[9];
    int   n_exp;

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] p);
        @(posedge clk);
        #1;
        in_valid = v;
        in_pixel = p;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'd0);
    endtask

    task automatic send_frame(input int off, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 7));
                drive(1'b1, 8'(5*r + c + off));
            end
        end
    endtask

    task automatic clear_capture();
        capq.delete();
        lastq.delete();
        fd_count = 0;
    endtask

    task automatic check_frame(input string tag, input int base, input int off);
        for (int i = 0; i < n_exp; i++) begin
            if (base + i < capq.size()) begin
                check($sformatf("%s_win%0d", tag, i), 96'(capq[base+i]),
                      96'(mk(tbl[i].cr, tbl[i].cc, tbl[i].fd, off)));
                check($sformatf("%s_trig%0d", tag, i), 96'(lastq[base+i]),
                      96'(8'(5*(tbl[i].cr + 1) + (tbl[i].cc + 1) + off)));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 96'(capq.size()), 96'(base + i + 1));
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"},  96'(out_valid),  96'(0));
        check({tag, "_frame_done"}, 96'(frame_done), 96'(0));
        check({tag, "_out_row"},    96'(out_row),    96'(0));
        check({tag, "_out_col"},    96'(out_col),    96'(0));
        check({tag, "_window"},
              96'({win00, win01, win02, win10, win11, win12, win20, win21, win22}), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
`ifdef WIN_STRIDE2_EN
        n_exp  = 4;
        tbl[0] = '{1, 1, 1'b0};
        tbl[1] = '{1, 3, 1'b0};
        tbl[2] = '{3, 1, 1'b0};
        tbl[3] = '{3, 3, 1'b1};
`else
        n_exp  = 9;
        tbl[0] = '{1, 1, 1'b0};
        tbl[1] = '{1, 2, 1'b0};
        tbl[2] = '{1, 3, 1'b0};
        tbl[3] = '{2, 1, 1'b0};
        tbl[4] = '{2, 2, 1'b0};
        tbl[5] = '{2, 3, 1'b0};
        tbl[6] = '{3, 1, 1'b0};
        tbl[7] = '{3, 2, 1'b0};
        tbl[8] = '{3, 3, 1'b1};
`endif

        // Reset state
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame, in_valid held high
        clear_capture();
        send_frame(0, 1'b0);
        idle(3);
        check("t1_count", 96'(capq.size()), 96'(n_exp));
        check_frame("t1", 0, 0);
        check("t1_fd_count", 96'(fd_count), 96'(1));
        bad = 0;
        foreach (lastq[i]) if (lastq[i] == 8'd15 || lastq[i] == 8'd16) bad++;
        check("t1_row_boundary", 96'(bad), 96'(0));

        // Same frame with random idle gaps
        clear_capture();
        send_frame(0, 1'b1);
        idle(3);
        check("t2_count", 96'(capq.size()), 96'(n_exp));
        check_frame("t2", 0, 0);
        check("t2_fd_count", 96'(fd_count), 96'(1));

        // Reset pulsed after pixel 13
        for (int p = 0; p <= 13; p++) drive(1'b1, 8'(p));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_capture();
        send_frame(0, 1'b0);
        idle(3);
        check("t3_count", 96'(capq.size()), 96'(n_exp));
        check_frame("t3", 0, 0);

        // Two back-to-back frames, second offset by 100
        clear_capture();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(3);
        check("t4_count", 96'(capq.size()), 96'(2 * n_exp));
        check_frame("t4a", 0, 0);
        check_frame("t4b", n_exp, 100);
        check("t4_fd_count", 96'(fd_count), 96'(2));

        check("no_valid_in_idle", 96'(idle_viol), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
